// File: rtl/led_pwm_if.sv
// led_pwm_if -- single-cycle-ack Wishbone subset used by the LED PWM peripheral.
//
// Handshake: the master raises wb_cyc (with wb_we/wb_addr/wb_wdata stable) and
// holds it until it sees wb_ack. The slave registers wb_ack = wb_cyc && !wb_ack,
// so an access is taken on the edge where wb_cyc is high and wb_ack is low, and
// wb_ack/wb_rdata are valid together in the following cycle. Holding wb_cyc high
// yields one access (and one ack) every second cycle.
//
// Signals:
//   wb_addr  [1:0]  word address            (master -> slave)
//   wb_wdata [31:0] write data              (master -> slave)
//   wb_we           write qualifier         (master -> slave)
//   wb_cyc          bus cycle request       (master -> slave)
//   wb_rdata [31:0] registered read data    (slave -> master)
//   wb_ack          registered acknowledge  (slave -> master)
interface led_pwm_if;
  logic [1:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdata;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/led_pwm.sv
// led_pwm -- Wishbone-writable LED driver with per-LED enable and 8-bit PWM duty.
//
// Register map (word addresses):
//   0 EN    : bits[LED_COUNT-1:0] enable mask
//   1 DUTY  : 8 bits per LED, LED i at bits[8i+7:8i]
//   2 BLINK : bits[15:0] half_period (PWM frames), bits[16+LED_COUNT-1:16] blink mask
//             (present only with LED_PWM_BLINK_EN; otherwise reads 0, writes ignored)
//   3       : reads 0, writes ignored
//
// Optional feature macro: LED_PWM_BLINK_EN (blink stage gating selected LEDs).
//
// Ports:
//   clk    sole clock
//   reset  synchronous, active-high
//   wb     led_pwm_if.slave bus port (wb_addr/wb_wdata/wb_we/wb_cyc in, wb_rdata/wb_ack out)
//   led    registered LED drive, active-high
module led_pwm #(
  parameter int LED_COUNT = 2,
  parameter int PWM_DIV   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  led_pwm_if.slave             wb,
  output logic [LED_COUNT-1:0] led
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DW = 8 * LED_COUNT;

  // Bus state
  logic                 ack_q;
  logic [31:0]          rdata_q;
  logic [31:0]          rd_val;
  logic                 access;

  // Registers
  logic [LED_COUNT-1:0] en_q;
  logic [DW-1:0]        duty_q;

  // PWM timebase
  logic [PW-1:0]        prescale_q;
  logic [7:0]           pwm_count_q;
  logic                 tick;
  logic                 frame_end;

  logic [LED_COUNT-1:0] raw;
  logic [LED_COUNT-1:0] gate;
  logic [LED_COUNT-1:0] led_q;

  // Upper write-data bits beyond the implemented fields are intentionally dropped.
  logic                 unused_wdata;
  assign unused_wdata = ^wb.wb_wdata;

  assign access    = wb.wb_cyc && !ack_q;
  assign tick      = (prescale_q == PW'(PWM_DIV - 1));
  assign frame_end = tick && (pwm_count_q == 8'hFF);

  assign wb.wb_ack   = ack_q;
  assign wb.wb_rdata = rdata_q;
  assign led         = led_q;

  // Raw PWM level: 0xFF is forced fully on, so 0..254 give duty/256 and 255 gives 100%.
  always_comb begin
    raw = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      raw[i] = (duty_q[8*i +: 8] == 8'hFF) || (pwm_count_q < duty_q[8*i +: 8]);
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [15:0]          half_q;
  logic [LED_COUNT-1:0] mask_q;
  logic [15:0]          blink_cnt_q;
  logic                 phase_q;

  always_comb begin
    gate = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      gate[i] = !mask_q[i] || phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half_q      <= '0;
      mask_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (access && wb.wb_we && (wb.wb_addr == 2'd2)) begin
      // A BLINK write restarts the blink phase so a shorter half_period can
      // never leave the counter stranded above its compare value.
      half_q      <= wb.wb_wdata[15:0];
      mask_q      <= wb.wb_wdata[16 +: LED_COUNT];
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (half_q == 16'd0) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_q == half_q - 16'd1) begin
        blink_cnt_q <= '0;
        phase_q     <= !phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 16'd1;
      end
    end
  end
`else
  assign gate = '1;
`endif

  // Read mux, registered into rdata_q on a read access edge.
  always_comb begin
    rd_val = '0;
    case (wb.wb_addr)
      2'd0:    rd_val = 32'(en_q);
      2'd1:    rd_val = 32'(duty_q);
`ifdef LED_PWM_BLINK_EN
      2'd2:    rd_val = 32'({mask_q, half_q});
`endif
      default: rd_val = '0;
    endcase
  end

  // Bus handshake and EN/DUTY registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      en_q    <= '0;
      duty_q  <= '0;
    end else begin
      ack_q <= access;
      if (access && !wb.wb_we) begin
        rdata_q <= rd_val;
      end else begin
        rdata_q <= '0;
      end
      if (access && wb.wb_we) begin
        case (wb.wb_addr)
          2'd0:    en_q   <= wb.wb_wdata[LED_COUNT-1:0];
          2'd1:    duty_q <= wb.wb_wdata[DW-1:0];
          default: ;
        endcase
      end
    end
  end

  // Free-running PWM timebase; only reset touches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q  <= '0;
      pwm_count_q <= '0;
    end else begin
      if (tick) begin
        prescale_q  <= '0;
        pwm_count_q <= pwm_count_q + 8'd1;
      end else begin
        prescale_q  <= prescale_q + PW'(1);
      end
    end
  end

  // Output register: one stage behind the counter/register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      led_q <= en_q & raw & gate;
    end
  end

endmodule
